// File: rtl/sipo_rx_ctrl_pkg.sv
// Shared definitions for the serial frame receive controller.
//   state_t       : controller state encoding (IDLE / DATA / STOP)
//   DEFAULT_WIDTH : default number of data bits per frame
//   clog2()       : bit-counter width helper (never returns less than 1)
package sipo_rx_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    STOP = 2'b10
  } state_t;

  // Width needed to count 0 .. value-1; at least 1 bit so the counter
  // always has a legal declaration.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in / parallel-out shift register.
// Ports:
//   Clock : system clock, rising edge
//   rst   : asynchronous active-low reset
//   en    : shift SI into the MSB and move everything one place right
//   clr   : synchronous clear, takes priority over en
//   SI    : serial input bit
//   PO    : parallel output; the first bit shifted in ends up in the LSB
module sipo_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             SI,
  output logic [WIDTH-1:0] PO
);

  logic [WIDTH-1:0] sr;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge Clock or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else if (clr) begin
      sr <= '0;
    end else if (en) begin
      sr <= {SI, sr[WIDTH-1:1]};
    end
  end

  assign PO = sr;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Serial frame receive controller.
// Detects a start bit (SI low while enabled), shifts WIDTH data bits into a
// SIPO shift register, checks the stop bit and hands the word to a consumer
// over a valid/ready handshake.
// Ports:
//   Clock     : system clock, rising edge
//   rst       : asynchronous active-low reset
//   SI        : serial line, idles high
//   enable    : receiver enable; low forces / keeps the controller in IDLE
//   data      : last accepted word, LSB = first data bit received
//   valid     : data holds an unconsumed word
//   ready     : consumer takes data on an edge where valid & ready
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   overrun   : sticky, a completed word was dropped
//   ovr_clr   : synchronous clear of overrun (a simultaneous set wins)
//   busy      : high while the controller is not in IDLE
module sipo_rx_ctrl
  import sipo_rx_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clock,
  input  logic             rst,
  input  logic             SI,
  input  logic             enable,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             frame_err,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             busy
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             sr_en, sr_clr;
  logic [WIDTH-1:0] sr_po;
  logic             stop_good, stop_bad;

  sipo_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift (
    .Clock (Clock),
    .rst   (rst),
    .en    (sr_en),
    .clr   (sr_clr),
    .SI    (SI),
    .PO    (sr_po)
  );

  always_ff @(posedge Clock or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every signal written here gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sr_en      = 1'b0;
    sr_clr     = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    if (!enable) begin
      // Abort from any state: no word, no framing error.
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!SI) begin
            state_next = DATA;
            cnt_next   = '0;
            sr_clr     = 1'b1;
          end
        end
        DATA: begin
          sr_en = 1'b1;
          if (cnt == LAST_BIT) begin
            state_next = STOP;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        STOP: begin
          // Straight back to IDLE so the next start bit can follow at once.
          state_next = IDLE;
          stop_good  = SI;
          stop_bad   = !SI;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Registered outputs; busy is taken from the next state so it is a flop
  // that lines up with the state register.
  always_ff @(posedge Clock or negedge rst) begin
    if (!rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      busy      <= (state_next != IDLE);

      if (stop_good) begin
        // A pending word being consumed on this edge frees the slot.
        if (!valid || ready) begin
          data  <= sr_po;
          valid <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      if (stop_good && valid && !ready) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Self-checking bench for sipo_rx_ctrl (WIDTH = 8).
// Directed frames from the test plan followed by random line activity, all
// compared each cycle against a frame-level model built from a queue of
// collected bits.
module tb_sipo_rx_ctrl;

  localparam int W = 8;

  logic         Clock = 1'b0;
  logic         rst;
  logic         SI;
  logic         enable;
  logic         ready;
  logic         ovr_clr;
  logic [W-1:0] data;
  logic         valid;
  logic         frame_err;
  logic         overrun;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int valid_cycles[$];

  // Reference model state
  bit           m_in_frame;
  bit           m_bits[$];
  logic [W-1:0] m_data;
  bit           m_valid;
  bit           m_ferr;
  bit           m_ovr;
  bit           m_busy;

  always #5 Clock = ~Clock;

  sipo_rx_ctrl #(
    .WIDTH (W)
  ) dut (
    .Clock     (Clock),
    .rst       (rst),
    .SI        (SI),
    .enable    (enable),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 0;
    m_bits.delete();
    m_data  = '0;
    m_valid = 0;
    m_ferr  = 0;
    m_ovr   = 0;
    m_busy  = 0;
  endtask

  // One rising edge of the reference: frame = start bit, W data bits
  // (LSB first), stop bit.
  task automatic model_edge();
    bit           done    = 0;
    bit           set_ovr = 0;
    logic [W-1:0] word    = '0;
    m_ferr = 0;
    if (!enable) begin
      m_in_frame = 0;
      m_bits.delete();
    end else if (!m_in_frame) begin
      if (!SI) begin
        m_in_frame = 1;
        m_bits.delete();
      end
    end else if (m_bits.size() < W) begin
      m_bits.push_back(SI);
    end else begin
      m_in_frame = 0;
      if (SI) begin
        for (int i = 0; i < W; i++) word = word + (W'(m_bits[i]) << i);
        done = 1;
      end else begin
        m_ferr = 1;
      end
      m_bits.delete();
    end

    if (done) begin
      if (!m_valid) begin
        m_data  = word;
        m_valid = 1;
      end else if (ready) begin
        m_data = word;
      end else begin
        set_ovr = 1;
      end
    end else if (m_valid && ready) begin
      m_valid = 0;
    end

    if (set_ovr) m_ovr = 1;
    else if (ovr_clr) m_ovr = 0;
    m_busy = m_in_frame;
  endtask

  task automatic check_all();
    check("data",      data,      m_data);
    check("valid",     valid,     m_valid);
    check("frame_err", frame_err, m_ferr);
    check("overrun",   overrun,   m_ovr);
    check("busy",      busy,      m_busy);
  endtask

  // Drive inputs after the falling edge, apply one rising edge, compare on
  // the following falling edge.
  task automatic tick(input logic si, input logic en, input logic rdy, input logic clr);
    SI      = si;
    enable  = en;
    ready   = rdy;
    ovr_clr = clr;
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
    cyc++;
    check_all();
    if (valid) valid_cycles.push_back(cyc);
  endtask

  task automatic send_frame(input logic [W-1:0] word, input logic stop_bit,
                            input logic rdy_body, input logic rdy_stop,
                            input logic clr_stop);
    tick(1'b0, 1'b1, rdy_body, 1'b0);
    for (int i = 0; i < W; i++) tick(word[i], 1'b1, rdy_body, 1'b0);
    tick(stop_bit, 1'b1, rdy_stop, clr_stop);
  endtask

  initial begin
    rst = 1'b0; SI = 1'b1; enable = 1'b1; ready = 1'b0; ovr_clr = 1'b0;
    model_reset();

    // Reset held while the line toggles: everything stays at zero.
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      SI = 1'(i & 1);
      @(negedge Clock);
      check("rst_data",  data,      0);
      check("rst_valid", valid,     0);
      check("rst_ferr",  frame_err, 0);
      check("rst_ovr",   overrun,   0);
      check("rst_busy",  busy,      0);
    end
    SI = 1'b1;
    rst = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("idle_busy", busy, 0);

    // Good frame A5, then consume.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("a5_data", data, 8'hA5);
    check("a5_valid", valid, 1);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    check("a5_consumed", valid, 0);
    check("a5_kept", data, 8'hA5);

    // Overrun: A5 left pending, 3C dropped.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ovr_set", overrun, 1);
    check("ovr_data", data, 8'hA5);
    check("ovr_valid", valid, 1);
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    check("ovr_clr", overrun, 0);
    // Ready on the completion edge replaces the pending word.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    check("swap_data", data, 8'h3C);
    check("swap_ovr", overrun, 0);
    check("swap_valid", valid, 1);
    // Set and clear on the same edge: set wins.
    send_frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b1);
    check("ovr_set_wins", overrun, 1);
    check("ovr_set_wins_data", data, 8'h3C);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    check("drain_valid", valid, 0);

    // Framing error.
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ferr_pulse", frame_err, 1);
    check("ferr_valid", valid, 0);
    check("ferr_data", data, 8'h3C);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("ferr_one_cycle", frame_err, 0);

    // Abort after four data bits, then a clean 5A frame.
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("abort_busy", busy, 0);
    check("abort_ferr", frame_err, 0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    check("after_abort_data", data, 8'h5A);
    check("after_abort_valid", valid, 1);

    // Asynchronous reset in the middle of a frame.
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("async_data",  data,  0);
    check("async_valid", valid, 0);
    check("async_busy",  busy,  0);
    model_reset();
    @(negedge Clock);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("post_rst_valid", valid, 0);

    // Back-to-back frames with ready held high.
    valid_cycles.delete();
    send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
    check("b2b_0", data, 8'h01);
    send_frame(8'h80, 1'b1, 1'b1, 1'b1, 1'b0);
    check("b2b_1", data, 8'h80);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
    check("b2b_2", data, 8'hFF);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    check("b2b_count", valid_cycles.size(), 3);
    if (valid_cycles.size() == 3) begin
      check("b2b_gap0", valid_cycles[1] - valid_cycles[0], 10);
      check("b2b_gap1", valid_cycles[2] - valid_cycles[1], 10);
    end

    // Random line activity.
    for (int i = 0; i < 3000; i++) begin
      tick(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 39) != 0),
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
